// File: rtl/fetch_pkg.sv
// Shared types and constants for the stage-1 fetch unit.
package fetch_pkg;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch unit boundary: memory instruction port, decode handshake and redirect.
interface fetch_if;

  logic [31:0] instr_addr;
  logic        instr_stb;
  logic        instr_ack;
  logic [31:0] instr;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output instr_addr, instr_stb, id_valid, id_pc, id_instr,
    input  instr_ack, instr, id_ready, redirect, redirect_pc
  );

  modport slave (
    input  instr_addr, instr_stb, id_valid, id_pc, id_instr,
    output instr_ack, instr, id_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding {pc,instr} entries between fetch and decode.
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 64,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  // a push into a full FIFO is fine when the head leaves in the same cycle
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/fetch_unit.sv
// Stage-1 instruction fetch: PC, single-outstanding memory request FSM, redirect discard.
// Define FETCH_PREFETCH_EN to buffer BUF_DEPTH words ahead of decode (else one holding entry).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);

`ifdef FETCH_PREFETCH_EN
  localparam bit PREFETCH = 1'b1;
`else
  localparam bit PREFETCH = 1'b0;
`endif

  localparam int DEPTH = PREFETCH ? BUF_DEPTH : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic             discard_q, discard_d;

  logic             push, pop_fire, ack_take, room;
  fetch_entry_t     fifo_din, fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;

  assign pop_fire = ~fifo_empty & bus.id_ready & ~bus.redirect;
  assign ack_take = (state_q == ST_REQ) & bus.instr_ack;
  // the slot freed by a pop this cycle may be reused by the request issued now
  assign room     = (fifo_count - CNT_W'(pop_fire)) < CNT_W'(DEPTH);
  assign fifo_din = '{pc: fetch_pc_q, instr: bus.instr};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    discard_d  = discard_q;
    push       = 1'b0;
    if (bus.redirect) begin
      fetch_pc_d = word_align(bus.redirect_pc);
      if (ack_take) begin
        state_d   = ST_IDLE;
        discard_d = 1'b0;
      end else if (state_q == ST_REQ) begin
        discard_d = 1'b1;
      end
    end else if (ack_take) begin
      state_d = ST_IDLE;
      if (discard_q) begin
        discard_d = 1'b0;
      end else begin
        push       = ~fifo_full | pop_fire;
        fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
      end
    end else if ((state_q == ST_IDLE) && room) begin
      state_d    = ST_REQ;
      req_addr_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop_fire),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.instr_stb  = (state_q == ST_REQ);
  assign bus.instr_addr = req_addr_q;
  assign bus.id_valid   = ~fifo_empty;
  assign bus.id_pc      = fifo_empty ? 32'h0 : fifo_head.pc;
  assign bus.id_instr   = fifo_empty ? 32'h0 : fifo_head.instr;

endmodule
